// File: rtl/mem_wb_if.sv
// MEM-stage inputs and MEM/WB register outputs.
// The stage is the slave; the pipeline driving it is the master.
interface mem_wb_if;
  logic [31:0] ALU_result_MEM;
  logic [31:0] Read_Data_2_MEM;
  logic        BranchEQ_MEM;
  logic        BranchNE_MEM;
  logic        Zero_MEM;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic        MemToReg_MEM;
  logic        RegWrite_MEM;
  logic [4:0]  Write_register_MEM;
  logic        PCSrc_MEM;
  logic [31:0] Read_Data_WB;
  logic [31:0] ALU_result_WB;
  logic        MemToReg_WB;
  logic        RegWrite_WB;
  logic [4:0]  Write_register_WB;
  logic        mem_fault;

  modport master (
    output ALU_result_MEM, Read_Data_2_MEM,
    output BranchEQ_MEM, BranchNE_MEM, Zero_MEM,
    output MemRead_MEM, MemWrite_MEM,
    output MemToReg_MEM, RegWrite_MEM,
    output Write_register_MEM,
    input  PCSrc_MEM, Read_Data_WB, ALU_result_WB,
    input  MemToReg_WB, RegWrite_WB,
    input  Write_register_WB, mem_fault
  );

  modport slave (
    input  ALU_result_MEM, Read_Data_2_MEM,
    input  BranchEQ_MEM, BranchNE_MEM, Zero_MEM,
    input  MemRead_MEM, MemWrite_MEM,
    input  MemToReg_MEM, RegWrite_MEM,
    input  Write_register_MEM,
    output PCSrc_MEM, Read_Data_WB, ALU_result_WB,
    output MemToReg_WB, RegWrite_WB,
    output Write_register_WB, mem_fault
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage with data memory and MEM/WB register.
// Optional DMEM_RANGE_CHECK_EN enables alignment/range fault detection.
module mem_wb_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  mem_wb_if.slave  bus
);

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rdata;
  logic [31:0]       r_alu;
  logic              r_m2r;
  logic              r_rw;
  logic [4:0]        r_wreg;
  logic              r_fault;

  logic [ADDR_W-1:0] w_idx;
  logic              w_acc;
  logic              w_fault;
  logic              w_we;
  logic              w_re;
  logic [31:0]       w_rdata;

  assign w_idx = bus.ALU_result_MEM[ADDR_W+1:2];
  assign w_acc = bus.MemRead_MEM | bus.MemWrite_MEM;

`ifdef DMEM_RANGE_CHECK_EN
  assign w_fault = w_acc &
    ((|bus.ALU_result_MEM[1:0]) |
     (|bus.ALU_result_MEM[31:ADDR_W+2]));
`else
  assign w_fault = 1'b0;
`endif

  assign w_we    = bus.MemWrite_MEM & ~w_fault;
  assign w_re    = bus.MemRead_MEM & ~w_fault;
  assign w_rdata = w_re ? r_mem[w_idx] : 32'h0;

  // Contents survive reset; a store on an edge during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && w_we)
      r_mem[w_idx] <= bus.Read_Data_2_MEM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'h0;
      r_alu   <= 32'h0;
      r_m2r   <= 1'b0;
      r_rw    <= 1'b0;
      r_wreg  <= 5'd0;
      r_fault <= 1'b0;
    end else begin
      r_rdata <= w_rdata;
      r_alu   <= bus.ALU_result_MEM;
      r_m2r   <= bus.MemToReg_MEM;
      r_rw    <= bus.RegWrite_MEM;
      r_wreg  <= bus.Write_register_MEM;
      r_fault <= r_fault | w_fault;
    end
  end

  assign bus.PCSrc_MEM =
    (bus.BranchEQ_MEM & bus.Zero_MEM) |
    (bus.BranchNE_MEM & ~bus.Zero_MEM);

  assign bus.Read_Data_WB      = r_rdata;
  assign bus.ALU_result_WB     = r_alu;
  assign bus.MemToReg_WB       = r_m2r;
  assign bus.RegWrite_WB       = r_rw;
  assign bus.Write_register_WB = r_wreg;
  assign bus.mem_fault         = r_fault;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Covers reset, load/store, branches, read+write and range handling.
module tb_mem_wb_stage;

  logic clk;
  logic reset_n;
  int   n_tot;
  int   n_bad;

  mem_wb_if bus ();

  mem_wb_stage #(.DEPTH(256), .ADDR_W(8)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic rd,
                     input logic wr);
    bus.ALU_result_MEM  = a;
    bus.Read_Data_2_MEM = d;
    bus.MemRead_MEM     = rd;
    bus.MemWrite_MEM    = wr;
  endtask

  task automatic br(input logic eq, input logic ne,
                    input logic z, input logic exp,
                    input string tag);
    bus.BranchEQ_MEM = eq;
    bus.BranchNE_MEM = ne;
    bus.Zero_MEM     = z;
    #1;
    chk(tag, {31'd0, bus.PCSrc_MEM}, {31'd0, exp});
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    reset_n = 1'b0;
    bus.BranchEQ_MEM       = 1'b0;
    bus.BranchNE_MEM       = 1'b0;
    bus.Zero_MEM           = 1'b0;
    bus.MemToReg_MEM       = 1'b1;
    bus.RegWrite_MEM       = 1'b1;
    bus.Write_register_MEM = 5'd7;
    drv(32'h55, 32'h99, 1'b1, 1'b0);

    // Reset held with live inputs
    repeat (3) step();
    chk("rst_rd",   bus.Read_Data_WB, 32'h0);
    chk("rst_alu",  bus.ALU_result_WB, 32'h0);
    chk("rst_ctl",  {30'd0, bus.MemToReg_WB, bus.RegWrite_WB}, 32'h0);
    chk("rst_wreg", {27'd0, bus.Write_register_WB}, 32'h0);
    chk("rst_flt",  {31'd0, bus.mem_fault}, 32'h0);

    reset_n = 1'b1;
    drv(32'h55, 32'h99, 1'b0, 1'b0);
    step();
    chk("rel_alu",  bus.ALU_result_WB, 32'h55);
    chk("rel_ctl",  {30'd0, bus.MemToReg_WB, bus.RegWrite_WB}, 32'h3);
    chk("rel_wreg", {27'd0, bus.Write_register_WB}, 32'h7);
    chk("rel_rd0",  bus.Read_Data_WB, 32'h0);

    // Store then load
    bus.MemToReg_MEM = 1'b0;
    bus.Write_register_MEM = 5'd12;
    drv(32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    step();
    chk("st_ctl", {30'd0, bus.MemToReg_WB, bus.RegWrite_WB}, 32'h1);
    drv(32'h10, 32'h0, 1'b1, 1'b0);
    step();
    chk("ld_data", bus.Read_Data_WB, 32'hDEADBEEF);
    chk("ld_alu",  bus.ALU_result_WB, 32'h10);
    chk("ld_wreg", {27'd0, bus.Write_register_WB}, 32'd12);
    drv(32'h10, 32'h0, 1'b0, 1'b0);
    step();
    chk("noread", bus.Read_Data_WB, 32'h0);

    // Branch decision
    br(1'b1, 1'b0, 1'b1, 1'b1, "beq_t");
    br(1'b1, 1'b0, 1'b0, 1'b0, "beq_nt");
    br(1'b0, 1'b1, 1'b0, 1'b1, "bne_t");
    br(1'b0, 1'b1, 1'b1, 1'b0, "bne_nt");
    br(1'b0, 1'b0, 1'b1, 1'b0, "nobr");
    br(1'b1, 1'b1, 1'b0, 1'b1, "both");
    br(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Read+write returns old contents
    drv(32'h20, 32'h1, 1'b0, 1'b1);
    step();
    drv(32'h20, 32'h2, 1'b1, 1'b1);
    step();
    chk("rw_old", bus.Read_Data_WB, 32'h1);
    drv(32'h20, 32'h0, 1'b1, 1'b0);
    step();
    chk("rw_new", bus.Read_Data_WB, 32'h2);

    // Out-of-range / misaligned access
    drv(32'h10, 32'hAAAA0004, 1'b0, 1'b1);
    step();
`ifdef DMEM_RANGE_CHECK_EN
    drv(32'h13, 32'h5555, 1'b0, 1'b1);
    step();
    chk("flt_set", {31'd0, bus.mem_fault}, 32'h1);
    chk("flt_ctl", {30'd0, bus.MemToReg_WB, bus.RegWrite_WB}, 32'h1);
    drv(32'h13, 32'h0, 1'b1, 1'b0);
    step();
    chk("flt_rd0", bus.Read_Data_WB, 32'h0);
    drv(32'h10, 32'h0, 1'b1, 1'b0);
    step();
    chk("flt_mem", bus.Read_Data_WB, 32'hAAAA0004);
    chk("flt_hold", {31'd0, bus.mem_fault}, 32'h1);
`else
    drv(32'h413, 32'h5555, 1'b0, 1'b1);
    step();
    chk("wrap_flt", {31'd0, bus.mem_fault}, 32'h0);
    drv(32'h10, 32'h0, 1'b1, 1'b0);
    step();
    chk("wrap_mem", bus.Read_Data_WB, 32'h5555);
    drv(32'h413, 32'h0, 1'b1, 1'b0);
    step();
    chk("wrap_ld", bus.Read_Data_WB, 32'h5555);
`endif

    // Asynchronous reset in the middle of a store
    drv(32'h30, 32'h11, 1'b0, 1'b1);
    step();
    drv(32'h30, 32'h77, 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_alu",  bus.ALU_result_WB, 32'h0);
    chk("ar_ctl",  {30'd0, bus.MemToReg_WB, bus.RegWrite_WB}, 32'h0);
    chk("ar_wreg", {27'd0, bus.Write_register_WB}, 32'h0);
    chk("ar_flt",  {31'd0, bus.mem_fault}, 32'h0);
    repeat (2) step();
    chk("ar_hold", bus.ALU_result_WB, 32'h0);
    chk("ar_hrd",  bus.Read_Data_WB, 32'h0);
    drv(32'h30, 32'h0, 1'b1, 1'b0);
    reset_n = 1'b1;
    step();
    chk("ar_nowr", bus.Read_Data_WB, 32'h11);
    chk("ar_run",  bus.ALU_result_WB, 32'h30);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the five-stage pipeline plus the MEM/WB pipeline register. Consumes the registered outputs of the EX/MEM register, performs data-memory loads and stores, resolves the branch decision (PCSrc) for the fetch stage, and registers load data, ALU result and writeback controls toward the WB stage.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words in data memory
- ADDR_W, 8, word-address width; DEPTH == 2**ADDR_W

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ALU_result_MEM  in  32  byte address for loads/stores; passthrough result otherwise
- Read_Data_2_MEM  in  32  store data
- BranchEQ_MEM, BranchNE_MEM  in  1 each  branch type
- Zero_MEM  in  1  ALU zero flag
- MemRead_MEM, MemWrite_MEM, MemToReg_MEM, RegWrite_MEM  in  1 each  controls
- Write_register_MEM  in  5  destination register
- PCSrc_MEM  out  1  combinational: (BranchEQ_MEM & Zero_MEM) | (BranchNE_MEM & ~Zero_MEM)
- Read_Data_WB  out  32  registered load data
- ALU_result_WB  out  32  registered ALU result
- MemToReg_WB, RegWrite_WB  out  1 each  registered controls
- Write_register_WB  out  5  registered destination
- mem_fault  out  1  sticky access-fault flag (see Configuration)

## Operation
- Word index = ALU_result_MEM[ADDR_W+1:2].
- Store: MemWrite_MEM=1 at posedge clk writes Read_Data_2_MEM to memory[index]; 32-bit word stores only.
- Load: MemRead_MEM=1 reads memory[index] combinationally; value captured into Read_Data_WB at posedge.
- MemRead_MEM=0: Read_Data_WB captures 32'h0.
- MemRead_MEM and MemWrite_MEM both 1 (illegal encoding): write performed; Read_Data_WB gets pre-write contents (read-before-write).
- ALU_result_WB, MemToReg_WB, RegWrite_WB, Write_register_WB capture their _MEM inputs every posedge.
- PCSrc_MEM purely combinational; BranchEQ_MEM and BranchNE_MEM both 1 yields 1 (either condition true).
- No stall or flush inputs; stage advances every cycle.

## Timing
- Latency: _MEM inputs to _WB outputs one clock edge.
- Store at edge N visible to a load presented in cycle N+1 (captured at edge N+1).
- Reset (reset_n=0, any time incl. mid-access): all _WB outputs and mem_fault go to 0 immediately; store in progress on a coincident edge is dropped. Memory contents not cleared by reset.
- First posedge after reset_n rises operates normally.

## Configuration
- Macro DMEM_RANGE_CHECK_EN.
- Defined: access (MemRead_MEM or MemWrite_MEM) with ALU_result_MEM[1:0]!=0 or ALU_result_MEM[31:ADDR_W+2]!=0 is faulting: write suppressed, Read_Data_WB captures 32'h0, mem_fault set at that edge and held until reset. Writeback controls still pass through unchanged.
- Not defined: address bits outside [ADDR_W+1:2] ignored (wraps modulo DEPTH, misalignment ignored); mem_fault tied 0.

## Test plan
- Reset: hold reset_n=0 with nonzero inputs and toggling clk -> all _WB outputs and mem_fault remain 0; release -> next edge captures inputs.
- Store/load: store 32'hDEADBEEF at address 0x10, next cycle load 0x10 -> Read_Data_WB=32'hDEADBEEF one edge later; ALU_result_WB=0x10.
- Branch: BranchEQ=1,Zero=1 -> PCSrc_MEM=1; BranchEQ=1,Zero=0 -> 0; BranchNE=1,Zero=0 -> 1; no branch -> 0.
- Illegal read+write at 0x20 holding 32'h1, store 32'h2 -> Read_Data_WB=32'h1; later load 0x20 -> 32'h2.
- With DMEM_RANGE_CHECK_EN: store to 0x13 -> mem_fault=1, memory[4] unchanged, flag holds until reset_n=0; without macro: store to 0x413 (DEPTH 256) writes memory[4], mem_fault=0.
- Async reset mid-store: assert reset_n=0 between edges with MemWrite=1 -> outputs clear immediately, no write on following edges while in reset.
